// File: rtl/ab_seq_pkg.sv
// Shared types and constants for the a/b vector sequencer: FSM states,
// default dwell, half-adder truth table and the vector-to-{a,b} mapping.
package ab_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DWELL_DEFAULT = 5;

    // Bit i is the expected output for vector i (a = i[1], b = i[0]).
    localparam logic [3:0] EXP_X_DEFAULT = 4'b0110;
    localparam logic [3:0] EXP_Y_DEFAULT = 4'b1000;

    function automatic logic [1:0] vec_ab(input logic [1:0] idx);
        return {idx[1], idx[0]};
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// 8-bit dwell counter: synchronous clear (load of zero), counts while enabled,
// saturates at DWELL-1 and flags that value on tick.
module dwell_timer #(
    parameter int DWELL = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    output logic [7:0] count,
    output logic       tick
);

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (en && (count != LAST)) begin
            count <= count + 8'd1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/ab_vector_sequencer.sv
// Drives a/b through vectors 00,01,10,11 with a programmable dwell, samples x/y
// once per vector against the expected truth table and reports err_mask/pass.
module ab_vector_sequencer
    import ab_seq_pkg::*;
#(
    parameter int         DWELL = DWELL_DEFAULT,
    parameter logic [3:0] EXP_X = EXP_X_DEFAULT,
    parameter logic [3:0] EXP_Y = EXP_Y_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       x,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_mask,
    output state_t     fsm_state
);

    // Sampling happens one edge before the vector boundary, so each vector
    // has been stable for DWELL-1 full cycles when x/y are compared.
    localparam logic [7:0] SAMPLE_CNT = 8'(DWELL - 2);

    state_t     state;
    logic [7:0] count;
    logic       tick;
    logic       sample;
    logic       mismatch;
    logic [3:0] hit;
    logic       timer_clear;
    logic       timer_en;

    assign sample      = (state == RUN) && (count == SAMPLE_CNT);
    assign mismatch    = (x != EXP_X[vec_idx]) || (y != EXP_Y[vec_idx]);
    assign hit         = mismatch ? (4'b0001 << vec_idx) : 4'b0000;
    assign timer_clear = ((state == IDLE) && start) || ((state == RUN) && tick);
    assign timer_en    = (state == RUN);
    assign fsm_state   = state;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .en    (timer_en),
        .count (count),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a        <= 1'b0;
            b        <= 1'b0;
            vec_idx  <= 2'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_mask <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        err_mask <= 4'd0;
                        pass     <= 1'b0;
                        vec_idx  <= 2'd0;
                        {a, b}   <= vec_ab(2'd0);
                    end
                end
                RUN: begin
                    if (sample) begin
                        err_mask <= err_mask | hit;
                        if (vec_idx == 2'd3) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= ((err_mask | hit) == 4'd0);
                        end
                    end
                    // The last vector leaves RUN at its sample edge, so tick only
                    // ever fires here for vectors 0..2.
                    if (tick) begin
                        vec_idx <= vec_idx + 2'd1;
                        {a, b}  <= vec_ab(vec_idx + 2'd1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
